audio_dac_i2s_tx: RTL and testbench
===================================

Name: audio_dac_i2s_tx

Overview:
- Serial transmit end of the audio DAC path. Accepts left/right samples on valid/ready streams and shifts them out on AUD_DACDAT in I2S format.
- Timing comes from the codec-mastered AUD_BCLK and AUD_DACLRCK, which are asynchronous inputs.
- Sits between the sample-processing logic and the codec pins, in place of the vendor audio core's DAC half.
- Everything runs on the 50 MHz system clock; the audio clocks are oversampled, never used as clocks.

Parameters:
- DATA_WIDTH, 32, width of the stream data ports.
- AUDIO_BITS, 24, bits serialized per channel slot: data[AUDIO_BITS-1:0], MSB first; must be <= DATA_WIDTH.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk, input, 1, system clock, 50 MHz.
- reset, input, 1, asynchronous active-low reset.
- left_data, input, DATA_WIDTH, left sample.
- left_valid, input, 1, left sample valid.
- left_ready, output, 1, left FIFO can accept.
- right_data, input, DATA_WIDTH, right sample.
- right_valid, input, 1, right sample valid.
- right_ready, output, 1, right FIFO can accept.
- AUD_BCLK, input, 1, codec bit clock (asynchronous).
- AUD_DACLRCK, input, 1, codec DAC LR clock (asynchronous); low = left, high = right.
- AUD_DACDAT, output, 1, serial DAC data (registered).
- underrun, output, 1, sticky flag: a slot started with its channel FIFO empty.
- underrun_clr, input, 1, single-cycle clear for underrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFOs empty; shift register and bit counter cleared.
  - AUD_DACDAT=0, underrun=0, left_ready=right_ready=0, FSM=SYNC, synchronizer flops=0.
- After reset release, ready outputs go 1 on the first clk edge.
- Input synchronization:
  - AUD_BCLK and AUD_DACLRCK each pass through 2-flop synchronizers, then a third flop for edge detection.
  - bclk_fall = sync high-to-low.
  - lr_edge = any sync transition.
- Stream side:
  - A transfer happens when valid && ready at a clk edge.
  - ready = FIFO not full, derived from the registered count.
  - Full FIFO: ready=0 even if a pop occurs the same cycle.
  - Push into an empty FIFO while a pop is attempted the same cycle: the pop sees empty (underrun), the push is stored.
  - Left and right FIFOs are independent; channel alignment is the producer's responsibility.
- FSM states: SYNC, LOAD, SHIFT, PAD.
  - SYNC: AUD_DACDAT=0; ignore bclk_fall; on lr_edge go to LOAD. FIFOs accept data in SYNC.
  - LOAD (entered the same cycle lr_edge is seen):
    - Channel = new sync LRCK level (0 = left).
    - If that FIFO is non-empty: pop its head into the shift register. Otherwise load 0 and set underrun.
    - bit_cnt=0; AUD_DACDAT=0 (I2S one-BCLK delay slot).
    - Go to SHIFT.
  - SHIFT: on each bclk_fall, AUD_DACDAT <= shreg[AUDIO_BITS-1], shift left by 1, bit_cnt++. After AUDIO_BITS bits are driven, go to PAD.
  - PAD: on each bclk_fall, AUD_DACDAT <= 0.
  - SHIFT or PAD: on lr_edge, go to LOAD. A truncated word is abandoned without error.
- Priority: lr_edge beats bclk_fall in the same clk cycle. The bclk_fall that coincides with the LRCK change is the delay slot.
- Latency:
  - AUD_DACDAT changes 3 clk cycles (60 ns) after the AUD_BCLK falling pin edge.
  - The codec samples on the BCLK rising edge; this holds for BCLK up to 6.25 MHz.
- underrun:
  - Set when LOAD finds its FIFO empty; stays set until underrun_clr=1.
  - Set and clear in the same cycle: set wins.
- BCLK stopping mid-word: the FSM holds its state and AUD_DACDAT holds its value indefinitely.
- Reset mid-word: immediate return to the reset values. After release, no data is driven until a new lr_edge (SYNC).

Test Plan:
- Bench clocking: BCLK = 3.125 MHz (16 clk per period), LRCK = BCLK/64.
- Reset, then push left=0x00A5A5A5 and right=0x00123456, then run one frame -> the left slot shows 0 (delay bit), then bits 101001011010010110100101 MSB first, then 7 padding zeros. The right slot shows 000100100011010001010110. underrun=0.
- Push 5 left samples with no LRCK running -> 4 accepted, left_ready=0 after the 4th. The first frame transmits the 1st sample; left_ready returns 1 one cycle after the pop.
- Run a frame with both FIFOs empty -> AUD_DACDAT=0 for the whole frame, underrun=1. Pulse underrun_clr -> underrun=0. Underrun recurring in the same cycle as the clear -> underrun stays 1.
- Force the LRCK edge on the 10th BCLK of the left slot (short frame) -> transmission aborts, the right sample loads immediately, delay bit 0, then right MSB.
- Assert reset at bit 12 of a slot holding 0x00FFFFFF -> AUD_DACDAT=0 asynchronously and FIFOs empty. After release the output stays 0 until the next LRCK edge, then frames normally.
- Check timing: measure the AUD_BCLK fall to AUD_DACDAT change -> exactly 3 clk cycles for every bit.

Source files
------------

// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter for the codec DAC path: per-channel sample FIFOs feed a shift
// register clocked by oversampled, codec-mastered BCLK/LRCK on the system clock.
module audio_dac_i2s_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int AUDIO_BITS = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic                  left_valid,
  output logic                  left_ready,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  right_valid,
  output logic                  right_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_CNT_W = $clog2(AUDIO_BITS + 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LOAD,
    ST_SHIFT,
    ST_PAD
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [2:0]              r_bclk_sync;
  logic [2:0]              r_lr_sync;
  logic                    r_ready_en;
  logic [AUDIO_BITS-1:0]   r_shreg;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic                    r_dacdat;
  logic                    r_underrun;

  logic                    w_bclk_fall;
  logic                    w_lr_edge;
  logic                    w_chan;
  logic                    w_load;
  logic                    w_shift_bit;
  logic                    w_drive_zero;
  logic                    w_slot_empty;
  logic [AUDIO_BITS-1:0]   w_slot_head;
  logic [1:0]              w_push;
  logic [1:0]              w_pop;
  logic [1:0]              w_fifo_full;
  logic [1:0]              w_fifo_empty;
  logic [AUDIO_BITS-1:0]   w_in_data   [2];
  logic [AUDIO_BITS-1:0]   w_fifo_head [2];

  // Codec clocks: two flops for metastability, a third for edge detection.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_ready_en  <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], AUD_BCLK};
      r_lr_sync   <= {r_lr_sync[1:0], AUD_DACLRCK};
      r_ready_en  <= 1'b1;
    end
  end

  assign w_bclk_fall = r_bclk_sync[2] & ~r_bclk_sync[1];
  assign w_lr_edge   = r_lr_sync[2] ^ r_lr_sync[1];

  assign w_in_data[0] = left_data[AUDIO_BITS-1:0];
  assign w_in_data[1] = right_data[AUDIO_BITS-1:0];

  generate
    if (DATA_WIDTH > AUDIO_BITS) begin : g_unused
      logic w_unused_upper;
      assign w_unused_upper = ^{left_data[DATA_WIDTH-1:AUDIO_BITS],
                                right_data[DATA_WIDTH-1:AUDIO_BITS]};
    end
  endgenerate

  assign left_ready  = r_ready_en & ~w_fifo_full[0];
  assign right_ready = r_ready_en & ~w_fifo_full[1];
  assign w_push      = {right_valid & right_ready, left_valid & left_ready};

  // One FIFO per channel (0 = left, 1 = right); empty/full come from the
  // registered count, so a same-cycle push never rescues a pop from empty.
  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
      logic [AUDIO_BITS-1:0] r_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]      r_wr_ptr;
      logic [PTR_W-1:0]      r_rd_ptr;
      logic [CNT_W-1:0]      r_count;

      // NOTE: sample storage is deliberately not reset; the pointers and count
      // decide which entries are valid, and a reset memory costs routing.
      always_ff @(posedge clk) begin
        if (w_push[ch]) r_mem[r_wr_ptr] <= w_in_data[ch];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[ch]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (w_pop[ch])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          case ({w_push[ch], w_pop[ch]})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      assign w_fifo_full[ch]  = (r_count == CNT_W'(FIFO_DEPTH));
      assign w_fifo_empty[ch] = (r_count == '0);
      assign w_fifo_head[ch]  = r_mem[r_rd_ptr];
    end
  endgenerate

  // LOAD follows the LRCK edge by one cycle, so the synced level is settled.
  assign w_chan       = r_lr_sync[2];
  assign w_slot_empty = w_chan ? w_fifo_empty[1] : w_fifo_empty[0];
  assign w_slot_head  = w_chan ? w_fifo_head[1]  : w_fifo_head[0];
  assign w_pop[0]     = w_load & ~w_chan & ~w_fifo_empty[0];
  assign w_pop[1]     = w_load &  w_chan & ~w_fifo_empty[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SYNC;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift_bit  = 1'b0;
    w_drive_zero = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_lr_edge) begin
          w_next_state = ST_LOAD;
          w_drive_zero = 1'b1;
        end
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The BCLK fall coinciding with an LRCK change is the I2S delay slot.
        if (w_lr_edge) begin
          w_next_state = ST_LOAD;
          w_drive_zero = 1'b1;
        end else if (w_bclk_fall) begin
          w_shift_bit = 1'b1;
          if (r_bit_cnt == BIT_CNT_W'(AUDIO_BITS - 1)) w_next_state = ST_PAD;
        end
      end
      ST_PAD: begin
        if (w_lr_edge) begin
          w_next_state = ST_LOAD;
          w_drive_zero = 1'b1;
        end else if (w_bclk_fall) begin
          w_drive_zero = 1'b1;
        end
      end
      default: w_next_state = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_dacdat   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_shreg   <= w_slot_empty ? '0 : w_slot_head;
        r_bit_cnt <= '0;
      end else if (w_shift_bit) begin
        r_shreg   <= {r_shreg[AUDIO_BITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end

      if (w_drive_zero)     r_dacdat <= 1'b0;
      else if (w_shift_bit) r_dacdat <= r_shreg[AUDIO_BITS-1];

      // A new underrun outranks a coincident clear.
      if (w_load && w_slot_empty) r_underrun <= 1'b1;
      else if (underrun_clr)      r_underrun <= 1'b0;
    end
  end

  assign AUD_DACDAT = r_dacdat;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: stimulus queues one expected DACDAT bit per BCLK
// fall; an independent monitor checks each bit and its 3-cycle latency.
module tb_audio_dac_i2s_tx;

  localparam int DATA_WIDTH = 32;
  localparam int AUDIO_BITS = 24;
  localparam int FIFO_DEPTH = 4;

  logic                  clk;
  logic                  reset;
  logic [DATA_WIDTH-1:0] left_data;
  logic                  left_valid;
  logic                  left_ready;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  right_valid;
  logic                  right_ready;
  logic                  aud_bclk;
  logic                  aud_daclrck;
  logic                  aud_dacdat;
  logic                  underrun;
  logic                  underrun_clr;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 0;
  logic        exp_q[$];
  logic [31:0] left_q[$];
  logic [31:0] right_q[$];
  bit          m_active = 0;
  int          m_idx    = 0;
  logic [31:0] m_word   = '0;
  logic        exp_underrun = 1'b0;

  audio_dac_i2s_tx #(
    .DATA_WIDTH(DATA_WIDTH),
    .AUDIO_BITS(AUDIO_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .left_data   (left_data),
    .left_valid  (left_valid),
    .left_ready  (left_ready),
    .right_data  (right_data),
    .right_valid (right_valid),
    .right_ready (right_ready),
    .AUD_BCLK    (aud_bclk),
    .AUD_DACLRCK (aud_daclrck),
    .AUD_DACDAT  (aud_dacdat),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit ch, input logic [31:0] d, input bit accept);
    if (ch == 1'b0) begin
      check("left_ready_at_push", {31'b0, left_ready}, {31'b0, accept});
      left_data  = d;
      left_valid = 1'b1;
    end else begin
      check("right_ready_at_push", {31'b0, right_ready}, {31'b0, accept});
      right_data  = d;
      right_valid = 1'b1;
    end
    tick(1);
    left_valid  = 1'b0;
    right_valid = 1'b0;
    if (accept) begin
      if (ch == 1'b0) left_q.push_back(d);
      else            right_q.push_back(d);
    end
  endtask

  // One BCLK period starting with its falling edge; optionally toggles LRCK on
  // that fall and probes ready / drives underrun_clr around the FIFO pop.
  task automatic bclk_period(input bit toggle, input bit chk_ready, input bit clr_at_load);
    logic exp_bit;
    aud_bclk = 1'b0;
    if (toggle) begin
      aud_daclrck = ~aud_daclrck;
      m_active = 1'b1;
      m_idx    = 0;
      exp_bit  = 1'b0;
      if (aud_daclrck == 1'b0) begin
        if (left_q.size() > 0) m_word = left_q.pop_front();
        else begin m_word = '0; exp_underrun = 1'b1; end
      end else begin
        if (right_q.size() > 0) m_word = right_q.pop_front();
        else begin m_word = '0; exp_underrun = 1'b1; end
      end
    end else if (m_active && m_idx < AUDIO_BITS) begin
      exp_bit = m_word[AUDIO_BITS-1-m_idx];
      m_idx++;
    end else begin
      exp_bit = 1'b0;
    end
    exp_q.push_back(exp_bit);
    tick(3);
    if (chk_ready) check("left_ready_before_pop", {31'b0, left_ready}, 32'd0);
    if (clr_at_load) underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    if (chk_ready) check("left_ready_after_pop", {31'b0, left_ready}, 32'd1);
    tick(4);
    aud_bclk = 1'b1;
    tick(8);
  endtask

  task automatic run_slot(input int n_falls, input bit chk_ready, input bit clr_at_load);
    bclk_period(1'b1, chk_ready, clr_at_load);
    repeat (n_falls - 1) bclk_period(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_clear();
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    exp_underrun = 1'b0;
    check("underrun_after_clear", {31'b0, underrun}, 32'd0);
  endtask

  // Monitor: a BCLK fall seen on a negedge must leave DACDAT unchanged two
  // negedges later and show the queued bit three negedges later.
  initial begin
    bit   bclk_prev = 1'b1;
    bit   active    = 1'b0;
    int   cd        = 0;
    logic last_exp  = 1'b0;
    logic e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        active   = 1'b0;
        last_exp = 1'b0;
      end else begin
        if (active) begin
          cd++;
          if (cd == 2) check("dacdat_hold_2clk", {31'b0, aud_dacdat}, {31'b0, last_exp});
          if (cd == 3) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL scoreboard_empty: bclk fall with no expected bit at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              check("dacdat_bit_3clk", {31'b0, aud_dacdat}, {31'b0, e});
              last_exp = e;
            end
          end
        end
        if (bclk_prev && !aud_bclk) begin
          active = 1'b1;
          cd     = 0;
        end
      end
      bclk_prev = aud_bclk;
    end
  end

  initial begin
    reset        = 1'b0;
    left_data    = '0;
    left_valid   = 1'b0;
    right_data   = '0;
    right_valid  = 1'b0;
    aud_bclk     = 1'b1;
    aud_daclrck  = 1'b0;
    underrun_clr = 1'b0;

    // Reset values and ready release
    tick(3);
    check("reset_dacdat", {31'b0, aud_dacdat}, 32'd0);
    check("reset_underrun", {31'b0, underrun}, 32'd0);
    check("reset_left_ready", {31'b0, left_ready}, 32'd0);
    check("reset_right_ready", {31'b0, right_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("ready_before_first_edge", {31'b0, left_ready}, 32'd0);
    tick(1);
    check("left_ready_after_release", {31'b0, left_ready}, 32'd1);
    check("right_ready_after_release", {31'b0, right_ready}, 32'd1);
    mon_en = 1'b1;

    // Basic frame: lead-in right slot, then left A5A5A5, right 123456
    push(1'b1, 32'hFF80_0001, 1'b1);
    push(1'b0, 32'h00A5_A5A5, 1'b1);
    push(1'b1, 32'h0012_3456, 1'b1);
    run_slot(32, 1'b0, 1'b0);
    run_slot(32, 1'b0, 1'b0);
    run_slot(32, 1'b0, 1'b0);
    check("underrun_basic", {31'b0, underrun}, {31'b0, exp_underrun});

    // FIFO full: 4 of 5 left pushes accepted; ready returns after the pop
    push(1'b1, 32'h0065_4321, 1'b1);
    push(1'b1, 32'h0080_0000, 1'b1);
    push(1'b1, 32'h0000_0001, 1'b1);
    push(1'b1, 32'h00AA_AAAA, 1'b1);
    push(1'b0, 32'h00C0_0003, 1'b1);
    push(1'b0, 32'h000F_0F0F, 1'b1);
    push(1'b0, 32'h0055_5555, 1'b1);
    push(1'b0, 32'h0081_8181, 1'b1);
    check("left_ready_full", {31'b0, left_ready}, 32'd0);
    push(1'b0, 32'h00DE_AD00, 1'b0);
    run_slot(32, 1'b1, 1'b0);
    repeat (7) run_slot(32, 1'b0, 1'b0);
    check("underrun_full_test", {31'b0, underrun}, {31'b0, exp_underrun});

    // Underrun: empty left slot sets it; clear; set coinciding with clear
    run_slot(32, 1'b0, 1'b0);
    check("underrun_set", {31'b0, underrun}, {31'b0, exp_underrun});
    pulse_clear();
    run_slot(32, 1'b0, 1'b1);
    check("underrun_set_beats_clear", {31'b0, underrun}, {31'b0, exp_underrun});
    pulse_clear();

    // Short left slot: LRCK edge on its 10th BCLK aborts the word
    push(1'b0, 32'h00FF_00FF, 1'b1);
    push(1'b1, 32'h00C3_C3C3, 1'b1);
    run_slot(9, 1'b0, 1'b0);
    run_slot(32, 1'b0, 1'b0);
    check("underrun_short_frame", {31'b0, underrun}, {31'b0, exp_underrun});

    // Reset at bit 12 of an all-ones word; stale FIFO contents must vanish
    push(1'b0, 32'h00FF_FFFF, 1'b1);
    push(1'b0, 32'h00AB_CDEF, 1'b1);
    push(1'b1, 32'h0077_7777, 1'b1);
    run_slot(13, 1'b0, 1'b0);
    mon_en = 1'b0;
    exp_q.delete();
    left_q.delete();
    right_q.delete();
    m_active     = 1'b0;
    exp_underrun = 1'b0;
    reset = 1'b0;
    #1;
    check("midword_reset_dacdat", {31'b0, aud_dacdat}, 32'd0);
    check("midword_reset_left_ready", {31'b0, left_ready}, 32'd0);
    check("midword_reset_right_ready", {31'b0, right_ready}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("left_ready_after_rerelease", {31'b0, left_ready}, 32'd1);
    mon_en = 1'b1;
    push(1'b1, 32'h00A0_0005, 1'b1);
    push(1'b0, 32'h0012_3456, 1'b1);
    repeat (19) bclk_period(1'b0, 1'b0, 1'b0);
    run_slot(32, 1'b0, 1'b0);
    run_slot(32, 1'b0, 1'b0);
    check("underrun_after_reset", {31'b0, underrun}, {31'b0, exp_underrun});

    tick(20);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
